// File: rtl/trap_detect_unit_if.sv
// Bus bundle between EXE operand select, the trap-detect stage, MEM and CP0.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both high; the sender
// holds valid and payload stable until that edge, and ready may depend combinationally on valid.
interface trap_detect_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_trap_op;
  logic [DATA_WIDTH-1:0] in_src_a;
  logic [DATA_WIDTH-1:0] in_src_b;
  logic [PC_WIDTH-1:0]   in_pc;
  logic                  in_bd;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_trap;
  logic [PC_WIDTH-1:0]   out_pc;
  logic                  exc_req;
  logic [4:0]            exc_code;
  logic [PC_WIDTH-1:0]   exc_epc;
  logic                  exc_bd;
  logic                  exc_ack;
  logic [CNT_WIDTH-1:0]  trap_count;

  // Pipeline/CP0 side that drives operands and consumes results.
  modport master (
    output in_valid, in_trap_op, in_src_a, in_src_b, in_pc, in_bd, flush, out_ready, exc_ack,
    input  in_ready, out_valid, out_trap, out_pc, exc_req, exc_code, exc_epc, exc_bd, trap_count
  );

  // The trap-detect unit itself.
  modport slave (
    input  in_valid, in_trap_op, in_src_a, in_src_b, in_pc, in_bd, flush, out_ready, exc_ack,
    output in_ready, out_valid, out_trap, out_pc, exc_req, exc_code, exc_epc, exc_bd, trap_count
  );
endinterface

// File: rtl/trap_detect_unit.sv
// Registered MIPS conditional-trap stage: one-entry result slot feeding MEM, plus a latched
// trap exception request to CP0 that stalls issue until acknowledged.
module trap_detect_unit #(
  parameter int         DATA_WIDTH   = 32,
  parameter int         PC_WIDTH     = 32,
  parameter int         CNT_WIDTH    = 16,
  parameter logic [4:0] EXCCODE_TRAP = 5'h0d
) (
  input  logic          clk,
  input  logic          resetn,
  trap_detect_unit_if.slave bus,
  output logic [0:0]    dbg_state
);

  localparam logic [2:0] OP_TEQ  = 3'd1;
  localparam logic [2:0] OP_TGE  = 3'd2;
  localparam logic [2:0] OP_TGEU = 3'd3;
  localparam logic [2:0] OP_TLT  = 3'd4;
  localparam logic [2:0] OP_TLTU = 3'd5;
  localparam logic [2:0] OP_TNE  = 3'd6;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_nxt;

  logic                  out_valid_q;
  logic                  out_trap_q;
  logic                  out_bd_q;
  logic [PC_WIDTH-1:0]   out_pc_q;
  logic [PC_WIDTH-1:0]   exc_epc_q;
  logic                  exc_bd_q;
  logic [CNT_WIDTH-1:0]  trap_count_q;

  logic                  cmp_trap;
  logic                  in_ready_c;
  logic                  accept;
  logic                  out_fire;
  logic                  raise;
  logic [PC_WIDTH-1:0]   epc_c;

  // Trap condition on the full operand width.
  always_comb begin
    cmp_trap = 1'b0;
    case (bus.in_trap_op)
      OP_TEQ:  cmp_trap = (bus.in_src_a == bus.in_src_b);
      OP_TGE:  cmp_trap = ($signed(bus.in_src_a) >= $signed(bus.in_src_b));
      OP_TGEU: cmp_trap = (bus.in_src_a >= bus.in_src_b);
      OP_TLT:  cmp_trap = ($signed(bus.in_src_a) <  $signed(bus.in_src_b));
      OP_TLTU: cmp_trap = (bus.in_src_a <  bus.in_src_b);
      OP_TNE:  cmp_trap = (bus.in_src_a != bus.in_src_b);
      default: cmp_trap = 1'b0;
    endcase
  end

  // resetn gates ready so the input port reads as closed while reset is held.
  assign in_ready_c = resetn && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept     = bus.in_valid && in_ready_c;
  assign out_fire   = out_valid_q && bus.out_ready && !bus.flush;

  // Result slot: flush wins, then a new accept refills it, otherwise a fire empties it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_trap_q  <= 1'b0;
      out_bd_q    <= 1'b0;
      out_pc_q    <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_trap_q  <= cmp_trap;
      out_bd_q    <= bus.in_bd;
      out_pc_q    <= bus.in_pc;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Only a trap leaving the slot while idle is committed; acks outside PENDING are dropped.
  always_comb begin
    state_nxt = state_q;
    raise     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (out_fire && out_trap_q) begin
          state_nxt = S_PENDING;
          raise     = 1'b1;
        end
      end
      S_PENDING: begin
        if (bus.exc_ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign epc_c = out_bd_q ? (out_pc_q - PC_WIDTH'(4)) : out_pc_q;

  // EPC/BD are latched on raise and kept after the ack for CP0 to read back.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_epc_q <= '0;
      exc_bd_q  <= 1'b0;
    end else if (raise) begin
      exc_epc_q <= epc_c;
      exc_bd_q  <= out_bd_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trap_count_q <= '0;
    end else if (raise && (trap_count_q != {CNT_WIDTH{1'b1}})) begin
      trap_count_q <= trap_count_q + CNT_WIDTH'(1);
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_trap   = out_trap_q;
  assign bus.out_pc     = out_pc_q;
  assign bus.exc_req    = (state_q == S_PENDING);
  assign bus.exc_code   = (state_q == S_PENDING) ? EXCCODE_TRAP : 5'd0;
  assign bus.exc_epc    = exc_epc_q;
  assign bus.exc_bd     = exc_bd_q;
  assign bus.trap_count = trap_count_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_trap_detect_unit.sv
// Self-checking bench for trap_detect_unit: directed scenarios plus randomized traffic against a
// queue-based reference model; a second instance covers 64-bit operands and a 4-bit counter.
module tb_trap_detect_unit;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  trap_detect_unit_if #(.DATA_WIDTH(32), .PC_WIDTH(32), .CNT_WIDTH(16)) bus0 ();
  trap_detect_unit_if #(.DATA_WIDTH(64), .PC_WIDTH(32), .CNT_WIDTH(4))  bus1 ();
  logic [0:0] dbg0;
  logic [0:0] dbg1;

  trap_detect_unit #(.DATA_WIDTH(32), .PC_WIDTH(32), .CNT_WIDTH(16), .EXCCODE_TRAP(5'h0d)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0), .dbg_state(dbg0)
  );
  trap_detect_unit #(.DATA_WIDTH(64), .PC_WIDTH(32), .CNT_WIDTH(4), .EXCCODE_TRAP(5'h0d)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1), .dbg_state(dbg1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of results in flight as {bd, trap, pc}, plus CP0-side exception state.
  logic [33:0] exp_q[$];
  logic        m_pending = 1'b0;
  logic [31:0] m_epc = '0;
  logic        m_bd = 1'b0;
  int          m_count = 0;
  logic        m_ready, m_accept, m_fire;
  logic [33:0] m_item;
  logic        cur_fl, cur_ack;

  function automatic logic ref_trap(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bias;
    bias = 32'h8000_0000;
    case (op)
      3'd1: return a == b;
      3'd2: return (a ^ bias) >= (b ^ bias);
      3'd3: return a >= b;
      3'd4: return (a ^ bias) < (b ^ bias);
      3'd5: return a < b;
      3'd6: return a != b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pending = 1'b0;
    m_epc     = '0;
    m_bd      = 1'b0;
    m_count   = 0;
  endtask

  // Drive one cycle of inputs at the falling edge and work out what the handshake should do.
  task automatic drive_inputs(input logic v, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] pc, input logic bd,
                              input logic ordy, input logic fl, input logic ack);
    @(negedge clk);
    bus0.in_valid   = v;
    bus0.in_trap_op = op;
    bus0.in_src_a   = a;
    bus0.in_src_b   = b;
    bus0.in_pc      = pc;
    bus0.in_bd      = bd;
    bus0.out_ready  = ordy;
    bus0.flush      = fl;
    bus0.exc_ack    = ack;
    cur_fl   = fl;
    cur_ack  = ack;
    m_ready  = resetn && !m_pending && (exp_q.size() == 0 || ordy) && !fl;
    m_accept = v && m_ready;
    m_fire   = (exp_q.size() != 0) && ordy && !fl;
    m_item   = {bd, ref_trap(op, a, b), pc};
    #1;
  endtask

  task automatic clock_edge();
    logic was_pending;
    @(posedge clk);
    was_pending = m_pending;
    if (m_pending && cur_ack) m_pending = 1'b0;
    if (!was_pending && m_fire && exp_q[0][32]) begin
      m_pending = 1'b1;
      m_bd      = exp_q[0][33];
      m_epc     = exp_q[0][33] ? exp_q[0][31:0] - 32'd4 : exp_q[0][31:0];
      if (m_count < 65535) m_count++;
    end
    if (cur_fl) begin
      exp_q.delete();
    end else begin
      if (m_fire) void'(exp_q.pop_front());
      if (m_accept) exp_q.push_back(m_item);
    end
    #1;
  endtask

  task automatic idle_bus1();
    bus1.in_valid = 0; bus1.in_trap_op = 0; bus1.in_src_a = '0; bus1.in_src_b = '0;
    bus1.in_pc = '0; bus1.in_bd = 0; bus1.flush = 0; bus1.out_ready = 1; bus1.exc_ack = 0;
  endtask

  task automatic test_reset();
    bus0.in_valid = 0; bus0.in_trap_op = 0; bus0.in_src_a = '0; bus0.in_src_b = '0;
    bus0.in_pc = '0; bus0.in_bd = 0; bus0.flush = 0; bus0.out_ready = 0; bus0.exc_ack = 0;
    idle_bus1();
    model_reset();
    #2;
    checks++;
    if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0 || bus0.exc_req !== 1'b0 ||
        bus0.trap_count !== 16'd0 || dbg0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: in_ready=%b out_valid=%b exc_req=%b count=%0d expected all 0",
               bus0.in_ready, bus0.out_valid, bus0.exc_req, bus0.trap_count);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b expected 1", bus0.in_ready);
    end
    // Reach PENDING with a second op in the slot, then drop reset mid-cycle.
    drive_inputs(1, 3'd1, 32'd7, 32'd7, 32'h0000_1000, 0, 1, 0, 0);
    clock_edge();
    drive_inputs(1, 3'd1, 32'd3, 32'd3, 32'h0000_1004, 1, 1, 0, 0);
    clock_edge();
    checks++;
    if (bus0.exc_req !== 1'b1 || bus0.trap_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_pre_pending: exc_req=%b count=%0d expected 1 and 1", bus0.exc_req, bus0.trap_count);
    end
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus0.exc_req !== 1'b0 || bus0.exc_code !== 5'd0 || bus0.exc_epc !== 32'd0 ||
        bus0.exc_bd !== 1'b0 || bus0.out_valid !== 1'b0 || bus0.out_trap !== 1'b0 ||
        bus0.out_pc !== 32'd0 || bus0.in_ready !== 1'b0 || bus0.trap_count !== 16'd0 || dbg0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pending: exc_req=%b code=%h epc=%h bd=%b ov=%b ot=%b opc=%h rdy=%b cnt=%0d expected all 0",
               bus0.exc_req, bus0.exc_code, bus0.exc_epc, bus0.exc_bd, bus0.out_valid, bus0.out_trap,
               bus0.out_pc, bus0.in_ready, bus0.trap_count);
    end
    bus0.in_valid = 0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rerelease_ready: in_ready=%b expected 1", bus0.in_ready);
    end
  endtask

  task automatic test_signed();
    logic [2:0] ops[4];
    logic       want[4];
    ops  = '{3'd4, 3'd5, 3'd3, 3'd2};
    want = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_inputs(1, ops[i], 32'hFFFF_FFFF, 32'd1, 32'h0000_2000 + 32'(i * 4), 0, 1, 0, 0);
      clock_edge();
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_trap !== want[i]) begin
        errors++;
        $display("FAIL signed_op%0d: out_valid=%b out_trap=%b expected 1 and %b", ops[i],
                 bus0.out_valid, bus0.out_trap, want[i]);
      end
      drive_inputs(0, 3'd0, '0, '0, '0, 0, 1, 0, 0);
      clock_edge();
      if (want[i]) begin
        drive_inputs(0, 3'd0, '0, '0, '0, 0, 1, 0, 1);
        clock_edge();
      end
    end
  endtask

  task automatic test_trap_epc();
    drive_inputs(1, 3'd1, 32'd5, 32'd5, 32'h8000_0100, 1, 1, 0, 0);
    clock_edge();
    drive_inputs(0, 3'd0, '0, '0, '0, 0, 1, 0, 0);
    clock_edge();
    checks++;
    if (bus0.exc_req !== 1'b1 || bus0.exc_epc !== 32'h8000_00FC || bus0.exc_bd !== 1'b1 ||
        bus0.exc_code !== 5'h0d) begin
      errors++;
      $display("FAIL trap_raise: req=%b epc=%h bd=%b code=%h expected 1 800000fc 1 0d",
               bus0.exc_req, bus0.exc_epc, bus0.exc_bd, bus0.exc_code);
    end
    for (int i = 0; i < 2; i++) begin
      drive_inputs(1, 3'd6, 32'd1, 32'd2, 32'h0000_3000, 0, 1, 0, 0);
      checks++;
      if (bus0.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL trap_stall: in_ready=%b expected 0", bus0.in_ready);
      end
      clock_edge();
    end
    drive_inputs(0, 3'd0, '0, '0, '0, 0, 1, 0, 1);
    clock_edge();
    checks++;
    if (bus0.exc_req !== 1'b0 || bus0.exc_code !== 5'd0 || bus0.exc_epc !== 32'h8000_00FC ||
        bus0.trap_count !== 16'(m_count)) begin
      errors++;
      $display("FAIL trap_ack: req=%b code=%h epc=%h count=%0d expected 0 00 800000fc %0d",
               bus0.exc_req, bus0.exc_code, bus0.exc_epc, bus0.trap_count, m_count);
    end
    drive_inputs(0, 3'd0, '0, '0, '0, 0, 1, 0, 1);
    clock_edge();
    checks++;
    if (bus0.exc_req !== 1'b0 || bus0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL trap_ack_idle: req=%b in_ready=%b expected 0 1", bus0.exc_req, bus0.in_ready);
    end
  endtask

  task automatic test_backpressure();
    drive_inputs(1, 3'd6, 32'd1, 32'd2, 32'h0000_0400, 0, 1, 0, 0);
    clock_edge();
    for (int i = 0; i < 3; i++) begin
      drive_inputs(1, 3'd1, 32'd9, 32'd9, 32'h0000_0500, 0, 0, 0, 0);
      checks++;
      if (bus0.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready_c%0d: in_ready=%b expected 0", i, bus0.in_ready);
      end
      clock_edge();
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_trap !== 1'b1 || bus0.out_pc !== 32'h0000_0400) begin
        errors++;
        $display("FAIL bp_hold_c%0d: ov=%b ot=%b pc=%h expected 1 1 00000400", i,
                 bus0.out_valid, bus0.out_trap, bus0.out_pc);
      end
    end
    drive_inputs(0, 3'd0, '0, '0, '0, 0, 1, 0, 0);
    clock_edge();
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.exc_req !== 1'b1 || bus0.exc_epc !== 32'h0000_0400) begin
      errors++;
      $display("FAIL bp_fire: ov=%b req=%b epc=%h expected 0 1 00000400",
               bus0.out_valid, bus0.exc_req, bus0.exc_epc);
    end
    drive_inputs(0, 3'd0, '0, '0, '0, 0, 1, 0, 1);
    clock_edge();
  endtask

  task automatic test_flush();
    int cnt_before;
    drive_inputs(1, 3'd6, 32'd1, 32'd2, 32'h0000_0600, 0, 1, 0, 0);
    clock_edge();
    cnt_before = m_count;
    drive_inputs(1, 3'd6, 32'd1, 32'd2, 32'h0000_0700, 0, 1, 1, 0);
    checks++;
    if (bus0.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: in_ready=%b expected 0", bus0.in_ready);
    end
    clock_edge();
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.exc_req !== 1'b0 || bus0.trap_count !== 16'(cnt_before)) begin
      errors++;
      $display("FAIL flush_race: ov=%b req=%b count=%0d expected 0 0 %0d",
               bus0.out_valid, bus0.exc_req, bus0.trap_count, cnt_before);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      drive_inputs($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b,
                   $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      checks++;
      if (bus0.in_ready !== m_ready) begin
        errors++;
        $display("FAIL rnd_ready_%0d: in_ready=%b expected %b", n, bus0.in_ready, m_ready);
      end
      clock_edge();
      checks++;
      if (bus0.out_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && (bus0.out_trap !== exp_q[0][32] || bus0.out_pc !== exp_q[0][31:0]))) begin
        errors++;
        $display("FAIL rnd_slot_%0d: ov=%b ot=%b pc=%h expected valid=%0d item=%h", n,
                 bus0.out_valid, bus0.out_trap, bus0.out_pc, exp_q.size(), exp_q.size() ? exp_q[0] : 34'd0);
      end
      checks++;
      if (bus0.exc_req !== m_pending || bus0.exc_code !== (m_pending ? 5'h0d : 5'h00) ||
          bus0.exc_epc !== m_epc || bus0.exc_bd !== m_bd || bus0.trap_count !== 16'(m_count)) begin
        errors++;
        $display("FAIL rnd_exc_%0d: req=%b code=%h epc=%h bd=%b cnt=%0d expected %b %h %h %b %0d", n,
                 bus0.exc_req, bus0.exc_code, bus0.exc_epc, bus0.exc_bd, bus0.trap_count,
                 m_pending, m_pending ? 5'h0d : 5'h00, m_epc, m_bd, m_count);
      end
    end
  endtask

  // Issue one op on the 64-bit instance with MEM always ready; ack any trap it raises.
  task automatic d1_issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic want_trap, input int tag);
    @(negedge clk);
    bus1.in_valid = 1; bus1.in_trap_op = op; bus1.in_src_a = a; bus1.in_src_b = b;
    bus1.in_pc = 32'h0000_1000; bus1.in_bd = 0;
    #1;
    checks++;
    if (bus1.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL w64_ready_%0d: in_ready=%b expected 1", tag, bus1.in_ready);
    end
    @(negedge clk);
    bus1.in_valid = 0;
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_trap !== want_trap) begin
      errors++;
      $display("FAIL w64_trap_%0d: ov=%b ot=%b expected 1 %b", tag, bus1.out_valid, bus1.out_trap, want_trap);
    end
    @(negedge clk);
    if (want_trap) begin
      checks++;
      if (bus1.exc_req !== 1'b1) begin
        errors++;
        $display("FAIL w64_req_%0d: exc_req=%b expected 1", tag, bus1.exc_req);
      end
      bus1.exc_ack = 1;
      @(negedge clk);
      bus1.exc_ack = 0;
    end
  endtask

  task automatic test_signed_64();
    d1_issue(3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 0);
    d1_issue(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1);
    d1_issue(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 2);
    d1_issue(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 3);
    // Differ only above bit 31: equality must see the upper half.
    d1_issue(3'd1, 64'h0000_0001_0000_0005, 64'h0000_0000_0000_0005, 1'b0, 4);
  endtask

  task automatic test_saturation();
    int base;
    base = 2;
    for (int i = 1; i <= 17; i++) begin
      d1_issue(3'd1, 64'd0, 64'd0, 1'b1, 100 + i);
      checks++;
      if (bus1.trap_count !== 4'((base + i) > 15 ? 15 : (base + i)) || bus1.exc_req !== 1'b0) begin
        errors++;
        $display("FAIL sat_count_%0d: count=%0d req=%b expected %0d 0", i, bus1.trap_count,
                 bus1.exc_req, (base + i) > 15 ? 15 : (base + i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_trap_epc();
    test_backpressure();
    test_flush();
    test_random();
    test_signed_64();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
